scope_trig_ctrl: RTL
====================

# scope_trig_ctrl

Trigger and capture sequencer for the scope front end. It takes the signed ADC sample stream and runs a hysteresis level comparator, the thresholded successor of the sign-only PWM comparator. It sequences an arm → pre-fill → wait-trigger → post-fill → done capture into a circular sample buffer through a simple write port. It sits between the ADC interface and the capture RAM / display readout logic.

## Interface
Parameters:
- DATA_W, 12: ADC sample width, two's complement
- ADDR_W, 10: capture buffer address width; DEPTH = 2**ADDR_W
- AUTO_TO, 65536: auto-trigger timeout in valid samples (used only with SCOPE_AUTO_TRIG_EN)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_ad_valid  in  1  sample strobe
- i_ad_data  in  DATA_W  signed sample
- i_arm  in  1  single-cycle pulse: start or restart a capture
- i_trig_level  in  DATA_W  signed trigger level, latched on i_arm
- i_hyst  in  DATA_W-1  unsigned hysteresis half-band, latched on i_arm
- i_edge  in  1  0 = rising, 1 = falling, latched on i_arm
- i_pre_cnt  in  ADDR_W  pre-trigger sample count, latched on i_arm
- i_auto  in  1  auto-trigger enable, latched on i_arm
- o_wr_en  out  1  buffer write strobe
- o_wr_addr  out  ADDR_W  buffer write address
- o_wr_data  out  DATA_W  buffer write data
- o_trig_addr  out  ADDR_W  address of the trigger sample
- o_cmp  out  1  hysteresis comparator state
- o_busy  out  1  capture in progress (PRE, WAIT_TRIG or POST)
- o_done  out  1  capture complete; level, held until next i_arm
- o_auto_flag  out  1  last capture was auto-triggered

## Operation
- **States:** IDLE, PRE, WAIT_TRIG, POST, DONE.
- **Reset:** state is IDLE. All outputs are 0. Latched configuration is 0.
- **i_arm:**
  - Honoured in every state; it aborts any capture in progress.
  - Latches the configuration, clears the address, sample counter, o_done and o_auto_flag, and moves to PRE.
  - i_pre_cnt values at or above DEPTH-1 are clamped to DEPTH-1.
- **Comparator:**
  - Updated on every valid sample in every state, using the latched level and hysteresis.
  - Set when data > level+hyst. Cleared when data < level−hyst. Otherwise holds.
  - Thresholds are computed in DATA_W+2 signed arithmetic, so there is no overflow.
- **Edge:** cmp 0→1 (rising) or 1→0 (falling), evaluated on the current valid sample.
- **PRE:**
  - Every valid sample is written.
  - After pre_cnt writes, go to WAIT_TRIG. pre_cnt=0 goes straight to WAIT_TRIG.
  - Edges are ignored in PRE.
- **WAIT_TRIG:**
  - Every valid sample is written. The address wraps mod DEPTH.
  - The sample that produces the selected edge is the trigger sample. It is written, its address is captured in o_trig_addr, and the state moves to POST.
- **POST:**
  - Writes DEPTH−1−pre_cnt further valid samples, then DONE.
  - The buffer then holds DEPTH samples, from o_trig_addr−pre_cnt to o_trig_addr+DEPTH−1−pre_cnt (mod DEPTH).
- **DONE:** no writes; waits for i_arm.
- **Invalid samples:** samples with i_ad_valid low are never written and never counted.

## Timing
- **Write path:**
  - One registered stage. A sample with i_ad_valid high at cycle t appears on o_wr_en/o_wr_addr/o_wr_data at t+1.
  - o_wr_addr is 0 for the first write after arm and increments by 1 per write.
- **o_cmp:** updates at t+1 for a sample at t.
- **Trigger:**
  - o_trig_addr is valid from t+1 for a trigger sample at t.
  - State shows POST at t+1.
- **o_done:** rises the cycle after the final o_wr_en pulse. o_busy falls in the same cycle.
- **i_arm with i_ad_valid in the same cycle:** arm wins; that sample is not written.
- **i_arm latency:** o_busy=1 and o_done=0 from the cycle after i_arm.
- **Trigger on the final PRE sample:** not possible, because edges are ignored in PRE.
- **Reset mid-capture:** immediate return to IDLE with all outputs 0.

## Configuration
- **Macro:** SCOPE_AUTO_TRIG_EN.
- **Defined:**
  - In WAIT_TRIG with latched i_auto=1, a valid-sample counter runs.
  - If it reaches AUTO_TO with no edge, the current valid sample is forced as the trigger sample, and o_auto_flag is set until the next i_arm.
  - The counter clears on entry to WAIT_TRIG.
- **Undefined:**
  - No counter is built.
  - i_auto is ignored and o_auto_flag is tied 0.
  - The port list is unchanged.

## Structure
- **Shared package scope_pkg:**
  - state enum (IDLE, PRE, WAIT_TRIG, POST, DONE)
  - default DATA_W and ADDR_W constants
  - edge-select encoding constants EDGE_RISE=0 and EDGE_FALL=1
- **Sub-module scope_hyst_cmp:**
  - The registered hysteresis comparator.
  - Inputs: sample, valid, level, hyst.
  - Outputs: cmp, plus a combinational next-cmp for edge detection.
- **Top level:** scope_trig_ctrl holds the FSM, counters, address and write register.

## Test plan
The bench uses ADDR_W=4 (DEPTH=16).
- **Basic capture with wrap:** level=0, hyst=10, rising, pre=4. Send 8 samples at −100, then +100, then 11 samples at +50 → 20 writes to addresses 0..15,0..3; trig_addr=8; o_done the cycle after the 20th write.
- **Hysteresis:** sample sequence −20,5,−5,5,15 → o_cmp rises only after 15. Then 5,−5 → o_cmp holds 1. Then −15 → o_cmp clears.
- **Falling edge with pre=0:** stream 100,100,−100 → no writes skipped, trig_addr=2, 15 writes after the trigger sample.
- **Re-arm during POST:** i_arm mid-capture → o_done stays 0 and the next write goes to address 0. Arm in the same cycle as a valid sample → that sample is not written.
- **Invalid samples and reset:** i_ad_valid gaps of 3 cycles → counts unaffected. i_rst in WAIT_TRIG → all outputs 0 next cycle.
- **Auto trigger** (SCOPE_AUTO_TRIG_EN, AUTO_TO=5, i_auto=1): constant −100 stream → trigger on the 5th WAIT_TRIG sample, o_auto_flag=1. Without the macro → never completes and o_auto_flag stays 0.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: shared definitions for the scope trigger/capture sequencer.
//   state_t      capture FSM states
//   DEF_DATA_W   default ADC sample width
//   DEF_ADDR_W   default capture buffer address width
//   EDGE_RISE / EDGE_FALL  encoding of the edge-select input
package scope_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_ADDR_W = 10;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/scope_hyst_cmp.sv
// scope_hyst_cmp: registered hysteresis level comparator.
//   clk, rst   clock, synchronous active-high reset
//   sample     signed ADC sample (DATA_W)
//   valid      sample strobe; the comparator only moves on valid samples
//   level      signed trigger level (DATA_W)
//   hyst       unsigned hysteresis half-band (DATA_W-1)
//   cmp        registered comparator state
//   cmp_next   combinational next state, used by the caller for edge detection
module scope_hyst_cmp
    import scope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              valid,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-2:0] hyst,
    output logic              cmp,
    output logic              cmp_next
);

    // Two guard bits: level +/- hyst can never wrap.
    localparam int EXT_W = DATA_W + 2;

    logic signed [EXT_W-1:0] sample_ext;
    logic signed [EXT_W-1:0] level_ext;
    logic signed [EXT_W-1:0] hyst_ext;
    logic signed [EXT_W-1:0] thr_hi;
    logic signed [EXT_W-1:0] thr_lo;

    assign sample_ext = {{2{sample[DATA_W-1]}}, sample};
    assign level_ext  = {{2{level[DATA_W-1]}}, level};
    assign hyst_ext   = {3'b000, hyst};
    assign thr_hi     = level_ext + hyst_ext;
    assign thr_lo     = level_ext - hyst_ext;

    always_comb begin
        cmp_next = cmp;
        if (valid) begin
            if (sample_ext > thr_hi) begin
                cmp_next = 1'b1;
            end else if (sample_ext < thr_lo) begin
                cmp_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= 1'b0;
        end else begin
            cmp <= cmp_next;
        end
    end

endmodule

// File: rtl/scope_trig_ctrl.sv
// scope_trig_ctrl: trigger and capture sequencer for the scope front end.
// Runs a hysteresis comparator on the ADC stream and sequences an
// arm -> pre-fill -> wait-trigger -> post-fill -> done capture into a
// circular buffer through a registered write port.
//
// Optional feature: define SCOPE_AUTO_TRIG_EN to build the auto-trigger
// timeout counter (AUTO_TO valid samples in WAIT_TRIG with i_auto latched).
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ad_valid/i_ad_data  sample strobe and signed sample
//   i_arm               start/restart pulse; latches the i_trig_level,
//                       i_hyst, i_edge, i_pre_cnt, i_auto configuration
//   o_wr_en/o_wr_addr/o_wr_data  registered capture buffer write port
//   o_trig_addr         buffer address of the trigger sample
//   o_cmp               comparator state
//   o_busy / o_done     capture in progress / capture complete (level)
//   o_auto_flag         last capture was auto-triggered
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset, nothing captured, waiting for i_arm
// PRE       | writing the pre-trigger samples, edges ignored
// WAIT_TRIG | writing samples circularly, looking for the selected edge
// POST      | writing the remaining DEPTH-1-pre_cnt samples after trigger
// DONE      | buffer complete, no writes, waiting for i_arm
module scope_trig_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int AUTO_TO = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ad_valid,
    input  logic [DATA_W-1:0] i_ad_data,
    input  logic              i_arm,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic [DATA_W-2:0] i_hyst,
    input  logic              i_edge,
    input  logic [ADDR_W-1:0] i_pre_cnt,
    input  logic              i_auto,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic              o_cmp,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_auto_flag
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] cfg_level;
    logic [DATA_W-2:0] cfg_hyst;
    logic              cfg_edge;
    logic [ADDR_W-1:0] cfg_pre;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] post_len;
    logic              cmp_next;
    logic              edge_hit;
    logic              capturing;
    logic              auto_hit;

    scope_hyst_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk      (i_clk),
        .rst      (i_rst),
        .sample   (i_ad_data),
        .valid    (i_ad_valid),
        .level    (cfg_level),
        .hyst     (cfg_hyst),
        .cmp      (o_cmp),
        .cmp_next (cmp_next)
    );

    // cmp_next equals o_cmp when no valid sample, so edges are valid-qualified.
    assign edge_hit  = (cfg_edge == EDGE_FALL) ? (o_cmp & ~cmp_next)
                                               : (~o_cmp & cmp_next);
    assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    // DEPTH-1-pre_cnt; an ADDR_W-bit i_pre_cnt never exceeds DEPTH-1, so
    // the clamp to DEPTH-1 holds by construction.
    assign post_len  = ADDR_MAX - cfg_pre;

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TO + 1);

    logic              cfg_auto;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_flag;

    // Down-counter loaded with AUTO_TO on WAIT_TRIG entry; the sample seen
    // at terminal count 1 is the AUTO_TO-th one and is forced as trigger.
    assign auto_hit    = cfg_auto && (auto_cnt == AUTO_W'(1));
    assign o_auto_flag = auto_flag;
`else
    logic unused_auto;

    assign auto_hit    = 1'b0;
    assign o_auto_flag = 1'b0;
    assign unused_auto = i_auto ^ (AUTO_TO == 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cfg_level   <= '0;
            cfg_hyst    <= '0;
            cfg_edge    <= EDGE_RISE;
            cfg_pre     <= '0;
            addr        <= '0;
            cnt         <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_trig_addr <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
            cfg_auto    <= 1'b0;
            auto_cnt    <= '0;
            auto_flag   <= 1'b0;
`endif
        end else begin
            o_wr_en <= 1'b0;
            // Busy/done lag the state by one cycle so done rises the cycle
            // after the final write; arm forces busy immediately.
            o_busy  <= i_arm || capturing;
            o_done  <= !i_arm && (state == DONE);

            if (i_arm) begin
                cfg_level <= i_trig_level;
                cfg_hyst  <= i_hyst;
                cfg_edge  <= i_edge;
                cfg_pre   <= i_pre_cnt;
                addr      <= '0;
                cnt       <= i_pre_cnt;
                state     <= (i_pre_cnt == '0) ? WAIT_TRIG : PRE;
`ifdef SCOPE_AUTO_TRIG_EN
                cfg_auto  <= i_auto;
                auto_cnt  <= AUTO_W'(AUTO_TO);
                auto_flag <= 1'b0;
`endif
            end else if (i_ad_valid && capturing) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= addr;
                o_wr_data <= i_ad_data;
                addr      <= addr + 1'b1;

                case (state)
                    PRE: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == ADDR_W'(1)) begin
                            state <= WAIT_TRIG;
`ifdef SCOPE_AUTO_TRIG_EN
                            auto_cnt <= AUTO_W'(AUTO_TO);
`endif
                        end
                    end
                    WAIT_TRIG: begin
                        if (edge_hit || auto_hit) begin
                            o_trig_addr <= addr;
                            cnt         <= post_len;
                            state       <= (post_len == '0) ? DONE : POST;
`ifdef SCOPE_AUTO_TRIG_EN
                            auto_flag   <= !edge_hit;
`endif
                        end
`ifdef SCOPE_AUTO_TRIG_EN
                        else if (auto_cnt != '0) begin
                            auto_cnt <= auto_cnt - 1'b1;
                        end
`endif
                    end
                    POST: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == ADDR_W'(1)) begin
                            state <= DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
